// File: rtl/vga_note_renderer.sv
// vga_note_renderer: two-stage pixel colour pipeline drawing falling diamond notes
// above a piano keyboard with pressed-key highlight and per-key wrong-press flash.
module vga_note_renderer #(
   parameter int          N_BLOCKS     = 3,
   parameter int          N_KEYS       = 16,
   parameter int          KEY_W        = 40,
   parameter int          KEY_GAP      = 5,
   parameter int          KEY_TOP      = 335,
   parameter int          H_START      = 144,
   parameter int          H_END        = 783,
   parameter int          V_START      = 35,
   parameter int          V_END        = 514,
   parameter int          INNER_R      = 10,
   parameter int          OUTER_R      = 30,
   parameter int          FLASH_FRAMES = 8,
   parameter logic [11:0] BG_COLOR     = 12'h45C
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  frame_tick,
   input  logic [N_BLOCKS-1:0]   block_ena,
   input  logic [16*N_BLOCKS-1:0] block_x,
   input  logic [16*N_BLOCKS-1:0] block_y,
   input  logic [15:0]           down,
   input  logic [15:0]           down_wrong,
   input  logic [15:0]           posx,
   input  logic [15:0]           posy,
   output logic [11:0]           RGB
);
   localparam int FW = $clog2(FLASH_FRAMES + 1);
   localparam logic [15:0] HS  = 16'(H_START);
   localparam logic [15:0] HE  = 16'(H_END);
   localparam logic [15:0] VS  = 16'(V_START);
   localparam logic [15:0] VE  = 16'(V_END);
   localparam logic [15:0] KT  = 16'(KEY_TOP);
   localparam logic [15:0] KS  = 16'(KEY_TOP + 10);
   localparam logic [15:0] KWD = 16'(KEY_W);
   localparam logic [15:0] KG  = 16'(KEY_GAP);
   localparam logic [15:0] KHI = 16'(KEY_W - KEY_GAP);
   localparam logic [15:0] NK  = 16'(N_KEYS);
   localparam logic [15:0] ORG = 16'(H_START - 1);
   localparam logic [18:0] R_IN  = 19'(INNER_R);
   localparam logic [18:0] R_OUT = 19'(OUTER_R);

   typedef enum logic [1:0] {R_BLACK, R_FIELD, R_KEY} region_t;

   region_t              reg_d, reg_q;
   logic [15:0]          rel, kq, koff;
   logic [3:0]           kidx_q;
   logic [N_BLOCKS-1:0]  in_d, out_d, in_q, out_q;
   logic signed [17:0]   dx, dy;
   logic [17:0]          ax, ay;
   logic [18:0]          d;
   logic [15:0]          dw_q;
   logic [FW-1:0]        flash_cnt [16];
   logic [11:0]          note_c, key_c;

   // Stripes, gaps and out-of-range keys all fold into R_BLACK so stage 2 only sees three cases
   always_comb begin
      rel   = posx - ORG;
      kq    = rel / KWD;
      koff  = rel % KWD;
      reg_d = (posx < HS || posx > HE || posy < VS || posy > VE) ? R_BLACK
            : posy < KT ? R_FIELD
            : (posy < KS || kq >= NK || koff < KG || koff > KHI) ? R_BLACK : R_KEY;
      dx    = '0;
      dy    = '0;
      ax    = '0;
      ay    = '0;
      d     = '0;
      in_d  = '0;
      out_d = '0;
      for (int i = 0; i < N_BLOCKS; i++) begin
         dx       = $signed({2'b00, posx}) - $signed({2'b00, block_x[16*i +: 16]});
         dy       = $signed({2'b00, posy}) - $signed({2'b00, block_y[16*i +: 16]});
         ax       = dx[17] ? $unsigned(-dx) : $unsigned(dx);
         ay       = dy[17] ? $unsigned(-dy) : $unsigned(dy);
         d        = {ax, 1'b0} + {1'b0, ay};
         in_d[i]  = block_ena[i] && d < R_IN;
         out_d[i] = block_ena[i] && d < R_OUT;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         reg_q  <= R_BLACK;
         kidx_q <= '0;
         in_q   <= '0;
         out_q  <= '0;
      end else if (ena) begin
         reg_q  <= reg_d;
         kidx_q <= kq[3:0];
         in_q   <= in_d;
         out_q  <= out_d;
      end

   // Flash counters ignore ena so a paused display still times out its flashes
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         dw_q <= '0;
         for (int k = 0; k < 16; k++) flash_cnt[k] <= '0;
      end else begin
         dw_q <= down_wrong;
         for (int k = 0; k < N_KEYS; k++)
            flash_cnt[k] <= (down_wrong[k] && !dw_q[k]) ? FW'(FLASH_FRAMES)
                          : (frame_tick && flash_cnt[k] != '0) ? flash_cnt[k] - 1'b1
                          : flash_cnt[k];
      end

   always_comb begin
      note_c = BG_COLOR;
      for (int i = N_BLOCKS - 1; i >= 0; i--)
         note_c = in_q[i] ? 12'hFFF : out_q[i] ? 12'hFF0 : note_c;
      key_c = down[kidx_q] ? 12'h0FF
            : (flash_cnt[kidx_q] != '0 || down_wrong[kidx_q]) ? 12'hF11 : 12'hFFF;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) RGB <= 12'h000;
      else if (ena) RGB <= reg_q == R_FIELD ? note_c : reg_q == R_KEY ? key_c : 12'h000;
endmodule

// File: tb/tb_vga_note_renderer.sv
// tb_vga_note_renderer: scoreboard bench; each driven pixel queues its expected colour,
// which is compared one enabled clock after the pixel is captured.
module tb_vga_note_renderer;
   logic        clk = 0, rst = 1, ena = 1, frame_tick = 0;
   logic [2:0]  block_ena = '0;
   logic [47:0] block_x = '0, block_y = '0;
   logic [15:0] down = '0, down_wrong = '0, posx = '0, posy = '0;
   logic [11:0] RGB;
   int          n_cmp = 0, n_bad = 0;

   typedef struct {
      bit          c;
      logic [11:0] e;
      string       t;
   } ent_t;

   ent_t sb[$];
   ent_t s1, o;

   vga_note_renderer dut (
      .clk(clk), .rst(rst), .ena(ena), .frame_tick(frame_tick),
      .block_ena(block_ena), .block_x(block_x), .block_y(block_y),
      .down(down), .down_wrong(down_wrong), .posx(posx), .posy(posy), .RGB(RGB)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: RGB=%h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic px(input int x, input int y, input logic [11:0] e, input bit c, input string t);
      @(negedge clk);
      posx = 16'(x);
      posy = 16'(y);
      sb.push_back('{c, e, t});
   endtask

   task automatic idle(input int n);
      repeat (n) px(100, 20, 12'h000, 0, "idle");
   endtask

   // checked pixel followed by padding so later input changes cannot reach its stage 2
   task automatic probe(input int x, input int y, input logic [11:0] e, input string t);
      px(x, y, e, 1, t);
      idle(2);
   endtask

   task automatic tick();
      @(negedge clk);
      frame_tick = 1;
      sb.push_back('{0, 12'h000, "tick"});
      @(negedge clk);
      frame_tick = 0;
      sb.push_back('{0, 12'h000, "tick"});
   endtask

   initial begin
      s1.c = 0;
      o.c  = 0;
      forever begin
         @(posedge clk);
         if (rst) s1.c = 0;
         else if (ena) begin
            o = s1;
            if (sb.size() > 0) s1 = sb.pop_front();
            else s1.c = 0;
            #1;
            if (o.c) check(o.t, RGB, o.e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         posx       = 16'($urandom);
         posy       = 16'($urandom);
         down       = 16'($urandom);
         down_wrong = 16'($urandom);
         block_ena  = 3'($urandom);
         block_x    = {16'($urandom), 32'($urandom)};
         block_y    = {16'($urandom), 32'($urandom)};
         frame_tick = 1'($urandom);
         check("rst_hold", RGB, 12'h000);
      end
      @(negedge clk);
      down = '0; down_wrong = '0; block_ena = '0; frame_tick = 0; rst = 0;
      probe(144, 35, 12'h45C, "rst_first_pixel");
      probe(250, 400, 12'hFFF, "rst_no_flash");

      px(143, 100, 12'h000, 1, "border_x_lo");
      px(784, 100, 12'h000, 1, "border_x_hi");
      px(400, 34, 12'h000, 1, "border_y_lo");
      px(400, 515, 12'h000, 1, "border_y_hi");
      px(400, 100, 12'h45C, 1, "latency_hit");
      px(143, 100, 12'h000, 1, "latency_after");
      px(783, 300, 12'h45C, 1, "field_x_last");
      px(144, 334, 12'h45C, 1, "field_y_last");
      idle(2);

      block_x = {16'd0, 16'd410, 16'd400};
      block_y = {16'd0, 16'd200, 16'd200};
      block_ena = 3'b011;
      px(400, 200, 12'hFFF, 1, "n0_core");
      px(412, 200, 12'hFF0, 1, "n0_rim_over_n1_core");
      px(400, 225, 12'hFF0, 1, "rim_d25");
      px(400, 231, 12'h45C, 1, "outside_d31");
      px(400, 209, 12'hFFF, 1, "core_d9");
      px(400, 210, 12'hFF0, 1, "core_edge_d10");
      px(400, 229, 12'hFF0, 1, "rim_d29");
      px(400, 230, 12'h45C, 1, "rim_edge_d30");
      idle(2);
      block_x[31:16] = 16'd500;
      px(500, 200, 12'hFFF, 1, "n1_core");
      px(500, 215, 12'hFF0, 1, "n1_rim");
      px(502, 200, 12'hFFF, 1, "n1_core_dx2");
      idle(2);
      block_x[47:32] = 16'd300; block_y[47:32] = 16'd100; block_ena = 3'b101;
      px(300, 100, 12'hFFF, 1, "n2_core");
      px(500, 200, 12'h45C, 1, "n1_disabled");
      idle(2);

      block_ena = '0; down = 16'h0001;
      px(170, 400, 12'h0FF, 1, "key0_down");
      px(146, 400, 12'h000, 1, "key_gap_koff3");
      px(210, 400, 12'hFFF, 1, "key1_up");
      px(170, 340, 12'h000, 1, "key_top_stripe");
      px(170, 344, 12'h000, 1, "stripe_last");
      px(170, 345, 12'h0FF, 1, "stripe_end");
      px(148, 400, 12'h0FF, 1, "koff5");
      px(147, 400, 12'h000, 1, "koff4");
      px(178, 400, 12'h0FF, 1, "koff35");
      px(179, 400, 12'h000, 1, "koff36");
      px(783, 400, 12'h000, 1, "kidx16");
      idle(2);

      down = '0; down_wrong = 16'h0004;
      idle(1);
      down_wrong = '0;
      probe(250, 400, 12'hF11, "flash_0");
      for (int t = 1; t <= 8; t++) begin
         tick();
         probe(250, 400, t < 8 ? 12'hF11 : 12'hFFF, $sformatf("flash_%0d", t));
      end

      down_wrong = 16'h0004;
      idle(1);
      down_wrong = '0; down = 16'h0004;
      probe(250, 400, 12'h0FF, "down_over_flash");
      down = '0;
      probe(250, 400, 12'hF11, "flash_after_down");

      down_wrong = 16'h0008; frame_tick = 1;
      idle(1);
      down_wrong = '0; frame_tick = 0;
      probe(290, 400, 12'hF11, "coinc_0");
      for (int t = 1; t <= 8; t++) begin
         tick();
         probe(290, 400, t < 8 ? 12'hF11 : 12'hFFF, $sformatf("coinc_%0d", t));
      end

      down_wrong = 16'h0004;
      idle(1);
      down_wrong = '0;
      probe(250, 400, 12'hF11, "pre_reset_flash");
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      check("rst_mid", RGB, 12'h000);
      @(negedge clk);
      rst = 0;
      probe(250, 400, 12'hFFF, "rst_cleared_flash");
      probe(144, 35, 12'h45C, "rst_valid_again");

      down_wrong = 16'h0004;
      idle(1);
      down_wrong = '0;
      px(400, 100, 12'h45C, 0, "pre_freeze");
      px(400, 100, 12'h45C, 0, "pre_freeze");
      px(400, 100, 12'h45C, 1, "pre_freeze");
      @(negedge clk);
      ena = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         posx = 16'(150 + i * 60);
         posy = 16'd400;
         frame_tick = (i < 8);
         check("freeze", RGB, 12'h45C);
      end
      @(negedge clk);
      ena = 1; frame_tick = 0;
      probe(250, 400, 12'hFFF, "tick_ungated");
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
